// File: rtl/mem_stage_pkg.sv
// Shared widths, stall/sl_bus bit positions and bus payload types for the MEM stage.
package mem_stage_pkg;

    localparam int unsigned EX_TO_MEM_WD = 90;
    localparam int unsigned MEM_TO_WB_WD = 70;
    localparam int unsigned MEM_TO_ID_WD = 38;
    localparam int unsigned STALL_BUS_WD = 6;
    localparam int unsigned SL_BUS_WD    = 14;
    localparam int unsigned DATA_WD      = 32;
    localparam int unsigned REG_ADDR_WD  = 5;
    localparam int unsigned WEN_WD       = 4;

    // Stall vector positions consumed by this stage
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // sl_bus bit positions (bits 5:0 are reserved)
    localparam int unsigned SL_LW  = 13;
    localparam int unsigned SL_SW  = 12;
    localparam int unsigned SL_LB  = 11;
    localparam int unsigned SL_LBU = 10;
    localparam int unsigned SL_LH  = 9;
    localparam int unsigned SL_LHU = 8;
    localparam int unsigned SL_SB  = 7;
    localparam int unsigned SL_SH  = 6;

    // EX->MEM payload, MSB first
    typedef struct packed {
        logic [SL_BUS_WD-1:0]   sl_bus;
        logic [DATA_WD-1:0]     pc;
        logic                   data_ram_en;
        logic [WEN_WD-1:0]      data_ram_wen;
        logic                   sel_rf_res;
        logic                   rf_we;
        logic [REG_ADDR_WD-1:0] rf_waddr;
        logic [DATA_WD-1:0]     ex_result;
    } ex_to_mem_t;

    // MEM->WB payload
    typedef struct packed {
        logic [DATA_WD-1:0]     pc;
        logic                   rf_we;
        logic [REG_ADDR_WD-1:0] rf_waddr;
        logic [DATA_WD-1:0]     rf_wdata;
    } mem_to_wb_t;

    // MEM->ID forwarding payload
    typedef struct packed {
        logic                   rf_we;
        logic [REG_ADDR_WD-1:0] rf_waddr;
        logic [DATA_WD-1:0]     rf_wdata;
    } mem_to_id_t;

    // Load-type flags handed to the aligner
    typedef struct packed {
        logic lw;
        logic lb;
        logic lbu;
        logic lh;
        logic lhu;
    } load_flags_t;

    // Extract the load flags from an sl_bus word
    function automatic load_flags_t get_load_flags(input logic [SL_BUS_WD-1:0] sl);
        load_flags_t f;
        f.lw  = sl[SL_LW];
        f.lb  = sl[SL_LB];
        f.lbu = sl[SL_LBU];
        f.lh  = sl[SL_LH];
        f.lhu = sl[SL_LHU];
        return f;
    endfunction

    // True when any load flag is set
    function automatic logic is_load(input load_flags_t f);
        return f.lw | f.lb | f.lbu | f.lh | f.lhu;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Little-endian byte/halfword/word selection and extension of the SRAM read word.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [DATA_WD-1:0] rd,
    input  logic [1:0]         addr,
    input  load_flags_t        flags,
    output logic [DATA_WD-1:0] word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword; halfword ignores addr[0]
    always_comb begin
        byte_sel = rd[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rd[31:16] : rd[15:0];
    end

    // Extend according to load type; no load yields zero
    always_comb begin
        word = '0;
        if (flags.lw) begin
            word = rd;
        end else if (flags.lb) begin
            word = {{24{byte_sel[7]}}, byte_sel};
        end else if (flags.lbu) begin
            word = {24'h000000, byte_sel};
        end else if (flags.lh) begin
            word = {{16{half_sel[15]}}, half_sel};
        end else if (flags.lhu) begin
            word = {16'h0000, half_sel};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX->MEM register, load-data hold across stalls,
// load alignment and write-back value selection for WB and ID forwarding.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [STALL_BUS_WD-1:0] stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [DATA_WD-1:0]      data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

    ex_to_mem_t         bus_in;
    ex_to_mem_t         bus_r;
    logic               held_valid;
    logic [DATA_WD-1:0] held_data;

    load_flags_t        flags_c;
    logic               is_load_c;
    logic [DATA_WD-1:0] rd_c;
    logic [DATA_WD-1:0] load_word_c;
    mem_to_wb_t         wb_c;
    mem_to_id_t         id_c;

    logic               ex_stop;
    logic               mem_stop;

    assign bus_in   = ex_to_mem_t'(ex_to_mem_bus);
    assign ex_stop  = (stall[STALL_EX]  == STOP);
    assign mem_stop = (stall[STALL_MEM] == STOP);

    assign flags_c   = get_load_flags(bus_r.sl_bus);
    assign is_load_c = is_load(flags_c);

    // Pipeline register: advance, insert a bubble, or hold
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_r <= '0;
        end else if (!ex_stop) begin
            bus_r <= bus_in;
        end else if (!mem_stop) begin
            bus_r <= '0;
        end
    end

    // Capture the one-cycle SRAM word on the first MEM stall cycle of a load;
    // any new contents in bus_r take priority and invalidate the copy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held_valid <= 1'b0;
            held_data  <= '0;
        end else if (!ex_stop || !mem_stop) begin
            held_valid <= 1'b0;
        end else if (is_load_c && !held_valid) begin
            held_valid <= 1'b1;
            held_data  <= data_sram_rdata;
        end
    end

    assign rd_c = held_valid ? held_data : data_sram_rdata;

    load_align u_load_align (
        .rd    (rd_c),
        .addr  (bus_r.ex_result[1:0]),
        .flags (flags_c),
        .word  (load_word_c)
    );

    // Write-back value and output bus assembly
    always_comb begin
        wb_c          = '0;
        wb_c.pc       = bus_r.pc;
        wb_c.rf_we    = bus_r.rf_we;
        wb_c.rf_waddr = bus_r.rf_waddr;
        wb_c.rf_wdata = bus_r.sel_rf_res ? load_word_c : bus_r.ex_result;
        id_c          = '0;
        id_c.rf_we    = wb_c.rf_we;
        id_c.rf_waddr = wb_c.rf_waddr;
        id_c.rf_wdata = wb_c.rf_wdata;
    end

    assign mem_to_wb_bus = wb_c;
    assign mem_to_id_bus = id_c;

    // Fields carried for other stages but not consumed here
    logic unused_bits_c;
    assign unused_bits_c = ^{stall[5], stall[2:0], bus_r.data_ram_en, bus_r.data_ram_wen,
                             bus_r.sl_bus[SL_SW], bus_r.sl_bus[SL_SB], bus_r.sl_bus[SL_SH],
                             bus_r.sl_bus[5:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// against a behavioural model of the stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  stall;
    logic [89:0] ex_bus;
    logic [31:0] rdata;
    wire  [69:0] wb;
    wire  [37:0] id;

    int checks   = 0;
    int failures = 0;

    // Model state: instruction resident in MEM, whether SRAM word is still live,
    // and the word remembered from the first cycle after issue
    logic [89:0] mdl_bus;
    logic        mdl_fresh;
    logic [31:0] mdl_word;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .stall           (stall),
        .ex_to_mem_bus   (ex_bus),
        .data_sram_rdata (rdata),
        .mem_to_wb_bus   (wb),
        .mem_to_id_bus   (id)
    );

    localparam logic [13:0] SL_NONE = 14'h0000;
    localparam logic [13:0] SL_LW   = 14'h2000;
    localparam logic [13:0] SL_SW   = 14'h1000;
    localparam logic [13:0] SL_LB   = 14'h0800;
    localparam logic [13:0] SL_LBU  = 14'h0400;
    localparam logic [13:0] SL_LH   = 14'h0200;
    localparam logic [13:0] SL_LHU  = 14'h0100;
    localparam logic [5:0]  ST_RUN  = 6'b000000;
    localparam logic [5:0]  ST_EX   = 6'b001111;
    localparam logic [5:0]  ST_MEM  = 6'b011111;

    function automatic logic [89:0] mk_bus(input logic [13:0] sl, input logic [31:0] pc,
                                           input logic sel, input logic we,
                                           input logic [4:0] waddr, input logic [31:0] res);
        logic en;
        logic [3:0] wen;
        en  = (sl != SL_NONE);
        wen = sl[12] ? 4'hF : 4'h0;
        return {sl, pc, en, wen, sel, we, waddr, res};
    endfunction

    // Load result from the spec's little-endian rules, using shifts and signed casts
    function automatic logic [31:0] ref_load(input logic [13:0] sl, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] by;
        logic [31:0] hw;
        by = (w >> (int'(a) * 8)) & 32'hFF;
        hw = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
        if (sl[13]) return w;
        if (sl[11]) return 32'($signed(by[7:0]));
        if (sl[10]) return by;
        if (sl[9])  return 32'($signed(hw[15:0]));
        if (sl[8])  return hw;
        return 32'h0;
    endfunction

    function automatic logic [69:0] model_wb();
        logic [31:0] word;
        logic [31:0] wdata;
        word  = mdl_fresh ? rdata : mdl_word;
        wdata = mdl_bus[38] ? ref_load(mdl_bus[89:76], mdl_bus[1:0], word) : mdl_bus[31:0];
        if (!resetn) return 70'h0;
        return {mdl_bus[75:44], mdl_bus[37], mdl_bus[36:32], wdata};
    endfunction

    task automatic model_reset();
        mdl_bus   = '0;
        mdl_fresh = 1'b1;
        mdl_word  = '0;
    endtask

    task automatic drive(input logic [5:0] s, input logic [89:0] b, input logic [31:0] r);
        stall  = s;
        ex_bus = b;
        rdata  = r;
    endtask

    // Advance one clock; the model sees the same inputs the DUT samples
    task automatic tick();
        if (!resetn) begin
            model_reset();
        end else if (!stall[3]) begin
            mdl_bus   = ex_bus;
            mdl_fresh = 1'b1;
        end else if (!stall[4]) begin
            mdl_bus   = '0;
            mdl_fresh = 1'b1;
        end else if (mdl_fresh) begin
            mdl_word  = rdata;
            mdl_fresh = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive(6'($urandom), {$urandom, $urandom, $urandom}, $urandom);
            @(posedge clk);
            #2;
            checks++;
            if (wb !== 70'h0) begin
                failures++;
                $display("FAIL reset_wb got=%h want=0", wb);
            end
            checks++;
            if (id !== 38'h0) begin
                failures++;
                $display("FAIL reset_id got=%h want=0", id);
            end
        end
        #1;
        resetn = 1'b1;
        drive(ST_RUN, mk_bus(SL_NONE, 32'h0000_1000, 1'b0, 1'b1, 5'd5, 32'h1234_5678), 32'h0);
        tick();
        drive(ST_RUN, '0, $urandom);
        #2;
        checks++;
        if (wb !== {32'h0000_1000, 1'b1, 5'd5, 32'h1234_5678}) begin
            failures++;
            $display("FAIL alu_wb got=%h want=%h", wb, {32'h0000_1000, 1'b1, 5'd5, 32'h1234_5678});
        end
        checks++;
        if (id !== {1'b1, 5'd5, 32'h1234_5678}) begin
            failures++;
            $display("FAIL alu_id got=%h want=%h", id, {1'b1, 5'd5, 32'h1234_5678});
        end
    endtask

    task automatic test_byte_half();
        logic [13:0] sl [4];
        logic [1:0]  off [4];
        logic [31:0] word [4];
        logic [31:0] want [4];
        sl[0] = SL_LB;  off[0] = 2'd3; word[0] = 32'h80AA_BBCC; want[0] = 32'hFFFF_FF80;
        sl[1] = SL_LBU; off[1] = 2'd1; word[1] = 32'h80AA_BBCC; want[1] = 32'h0000_00BB;
        sl[2] = SL_LH;  off[2] = 2'd2; word[2] = 32'h8001_7FFF; want[2] = 32'hFFFF_8001;
        sl[3] = SL_LHU; off[3] = 2'd0; word[3] = 32'h8001_7FFF; want[3] = 32'h0000_7FFF;
        drive(ST_RUN, mk_bus(sl[0], 32'h200, 1'b1, 1'b1, 5'd7, {30'h40, off[0]}), $urandom);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3)
                drive(ST_RUN, mk_bus(sl[i+1], 32'h204 + 32'(i*4), 1'b1, 1'b1, 5'd8,
                                     {30'h40, off[i+1]}), word[i]);
            else
                drive(ST_RUN, '0, word[i]);
            #2;
            checks++;
            if (wb[31:0] !== want[i]) begin
                failures++;
                $display("FAIL align_%0d got=%h want=%h", i, wb[31:0], want[i]);
            end
            tick();
        end
    endtask

    task automatic test_load_stall();
        logic [89:0] nxt;
        nxt = mk_bus(SL_NONE, 32'h300, 1'b0, 1'b1, 5'd9, 32'h0BAD_F00D);
        drive(ST_RUN, mk_bus(SL_LW, 32'h2FC, 1'b1, 1'b1, 5'd3, 32'h100), $urandom);
        tick();
        drive(ST_MEM, nxt, 32'hDEAD_BEEF);
        #2;
        checks++;
        if (wb[31:0] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL lw_first got=%h want=deadbeef", wb[31:0]);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(ST_MEM, nxt, 32'h0);
            #2;
            checks++;
            if (wb !== {32'h2FC, 1'b1, 5'd3, 32'hDEAD_BEEF}) begin
                failures++;
                $display("FAIL lw_held_%0d got=%h", i, wb);
            end
            tick();
        end
        drive(ST_RUN, nxt, 32'h0);
        #2;
        checks++;
        if (wb[31:0] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL lw_release got=%h want=deadbeef", wb[31:0]);
        end
        tick();
        drive(ST_RUN, '0, $urandom);
        #2;
        checks++;
        if (wb !== {32'h300, 1'b1, 5'd9, 32'h0BAD_F00D}) begin
            failures++;
            $display("FAIL after_stall got=%h", wb);
        end
        checks++;
        if (dut.held_valid !== 1'b0) begin
            failures++;
            $display("FAIL held_clear got=%b want=0", dut.held_valid);
        end
    endtask

    task automatic test_bubble();
        logic [69:0] want_b;
        drive(ST_RUN, mk_bus(SL_NONE, 32'h400, 1'b0, 1'b1, 5'd11, 32'h1111_2222), $urandom);
        tick();
        drive(ST_EX, mk_bus(SL_NONE, 32'h404, 1'b0, 1'b1, 5'd12, 32'h3333_4444), $urandom);
        tick();
        #1;
        checks++;
        if (wb !== 70'h0) begin
            failures++;
            $display("FAIL bubble got=%h want=0", wb);
        end
        drive(ST_RUN, mk_bus(SL_NONE, 32'h408, 1'b0, 1'b1, 5'd13, 32'h5555_6666), $urandom);
        tick();
        want_b = {32'h408, 1'b1, 5'd13, 32'h5555_6666};
        for (int i = 0; i < 3; i++) begin
            drive(ST_MEM, mk_bus(SL_NONE, 32'h40C, 1'b0, 1'b1, 5'd14, 32'h7777_8888), $urandom);
            #2;
            checks++;
            if (wb !== want_b) begin
                failures++;
                $display("FAIL stall_hold_%0d got=%h want=%h", i, wb, want_b);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive(ST_RUN, mk_bus(SL_LW, 32'h500, 1'b1, 1'b1, 5'd2, 32'h80), $urandom);
        tick();
        drive(ST_MEM, '0, 32'hCAFE_F00D);
        tick();
        drive(ST_MEM, '0, 32'h0);
        #1;
        checks++;
        if (wb[31:0] !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL pre_reset_hold got=%h want=cafef00d", wb[31:0]);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (wb !== 70'h0 || id !== 38'h0) begin
            failures++;
            $display("FAIL async_reset wb=%h id=%h want=0", wb, id);
        end
        checks++;
        if (dut.held_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_held got=%b want=0", dut.held_valid);
        end
        #1;
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        logic [13:0] kinds [7];
        logic [13:0] sl;
        logic [69:0] exp_wb;
        int          r;
        kinds[0] = SL_NONE; kinds[1] = SL_LW; kinds[2] = SL_LB; kinds[3] = SL_LBU;
        kinds[4] = SL_LH;   kinds[5] = SL_LHU; kinds[6] = SL_SW;
        for (int i = 0; i < 400; i++) begin
            sl = kinds[$urandom_range(0, 6)] | 14'($urandom_range(0, 63));
            r  = $urandom_range(0, 3);
            drive((r == 0) ? ST_RUN : (r == 1) ? ST_EX : ST_MEM,
                  mk_bus(sl, $urandom, |sl[13:8] & ~sl[12], ~sl[12], 5'($urandom), $urandom),
                  $urandom);
            #2;
            exp_wb = model_wb();
            checks++;
            if (wb !== exp_wb) begin
                failures++;
                $display("FAIL rand_wb cyc=%0d got=%h want=%h", i, wb, exp_wb);
            end
            checks++;
            if (id !== exp_wb[37:0]) begin
                failures++;
                $display("FAIL rand_id cyc=%0d got=%h want=%h", i, id, exp_wb[37:0]);
            end
            tick();
        end
    endtask

    initial begin
        resetn = 1'b0;
        drive(ST_RUN, '0, '0);
        model_reset();
        test_reset();
        test_byte_half();
        test_load_stall();
        test_bubble();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between EX and WB. Registers the EX→MEM bus under stall control and aligns and extends the data-SRAM read word for byte, halfword and word loads. Selects the write-back value and drives both the MEM→WB bus and the MEM→ID forwarding bus. It also holds load data stable across MEM stalls, because the SRAM read word is valid only in the first cycle after the request.

## Interface
- No module parameters. Widths come from lib/defines.vh:
  - `EX_TO_MEM_WD`=90
  - `MEM_TO_WB_WD`=70
  - `MEM_TO_ID_WD`=38
  - `StallBus`=6
  - `Stop`=1'b1, `NoStop`=1'b0
- clk  in  1  single clock, all state on posedge.
- resetn  in  1  asynchronous, active-low reset.
- stall  in  `StallBus`  global stall vector; this block uses stall[3] (EX) and stall[4] (MEM).
- ex_to_mem_bus  in  90  fields:
  - [89:76] sl_bus; bit 13 lw, 12 sw, 11 lb, 10 lbu, 9 lh, 8 lhu, 7 sb, 6 sh, 5:0 reserved (ignored).
  - [75:44] pc
  - [43] data_ram_en
  - [42:39] data_ram_wen
  - [38] sel_rf_res (1 = load result)
  - [37] rf_we
  - [36:32] rf_waddr
  - [31:0] ex_result (ALU result or memory address)
- data_sram_rdata  in  32  SRAM read word, valid the cycle after EX asserted the request.
- mem_to_wb_bus  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- mem_to_id_bus  out  38  {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}, for forwarding.

## Operation
- **Pipeline register `bus_r` (90 bits).**
  - resetn=0: cleared to 0 asynchronously.
  - stall[3]=Stop and stall[4]=NoStop: loads all-zero (bubble).
  - stall[3]=NoStop: loads ex_to_mem_bus.
  - Otherwise holds its value.
- **Load data hold.** Uses `held_valid` (1 bit) and `held_data` (32 bits).
  - Any `bus_r` load or bubble clears `held_valid`.
  - If `bus_r` holds a load (sl_bus bits 13, 11–8 any set), stall[4]=Stop and `held_valid`=0: capture data_sram_rdata into `held_data` and set `held_valid`=1.
  - Effective read word `rd` = held_valid ? held_data : data_sram_rdata.
- **Alignment.** Little-endian; byte k = rd[8k+7:8k], with k = ex_result[1:0].
  - lw: rd.
  - lb: sign-extend byte k. lbu: zero-extend byte k.
  - lh: sign-extend halfword ex_result[1] (rd[31:16] if 1, else rd[15:0]). lhu: zero-extend the same halfword.
  - No load flag set: 0.
  - ex_result[0] for halfword loads is ignored; no misalignment detection.
- **Write-back value.** rf_wdata = sel_rf_res ? aligned load : ex_result.
  - rf_we and rf_waddr pass through from `bus_r`.
  - Stores pass through with their rf_we as given (0 from EX).
- **Outputs.** Both output buses are combinational from `bus_r`, `held_*` and data_sram_rdata. mem_to_id_bus equals mem_to_wb_bus[37:0].

## Timing
- **Reset values.** While resetn=0, all outputs are 0: rf_we=0, pc=0, rf_wdata=0. This requires data_sram_rdata to be unused under a zero bus, which holds because sel_rf_res=0.
- **Latency.** An instruction presented on ex_to_mem_bus in cycle N appears on mem_to_wb_bus in cycle N+1. The load word is sampled from SRAM in that same cycle N+1.
- **Stall[4]=Stop.** Outputs are held constant for every stall cycle, including when the load result comes from `held_data` after cycle N+1.
- **Reset mid-stall.** Clears `held_valid` and `bus_r` immediately.
- **Simultaneous capture and load.** If `held_valid` would be captured while `bus_r` also loads, the load wins: `held_valid`=0.

## Structure
- sl_bus bit indices and bus widths are `define constants in lib/defines.vh, shared with EX and WB.
- Sub-module `load_align`: combinational, inputs rd, addr[1:0] and the 5 load flags; output 32-bit word.
- The hold register and the pipeline register stay in mem_stage.

## Test plan
- **Reset:** resetn=0 with random inputs → both buses 0. Release, then present an ALU op (rf_we=1, waddr=5, ex_result=0x1234_5678) → next cycle mem_to_wb_bus carries wdata 0x12345678, waddr 5, rf_we 1.
- **lb:** addr low bits 3, rdata=0x80AA_BBCC → wdata 0xFFFF_FF80. lbu at offset 1 with the same word → 0x0000_00BB.
- **lh / lhu:** lh at offset 2, rdata=0x8001_7FFF → 0xFFFF_8001. lhu at offset 0 → 0x0000_7FFF.
- **Load under stall:** lw with rdata=0xDEAD_BEEF, then stall[4]=Stop for 3 cycles while rdata changes to 0x0 → wdata stays 0xDEADBEEF every cycle. Release → the next instruction appears and `held_valid` clears.
- **Bubble:** stall[3]=Stop, stall[4]=NoStop → next cycle rf_we=0 and bus all-zero. stall[3]=Stop, stall[4]=Stop → previous contents held.
- **Async reset during a held load:** assert resetn=0 mid-cycle → outputs go to 0 without waiting for a clock edge.
